// File: rtl/msi_irq_scheduler.sv
// MSI request sequencer: folds collector vectors into the host-allocated range,
// drives the bridge req/grant handshake with timeout retry/drop and post-MSI holdoff.
module msi_irq_scheduler #(
    parameter int unsigned HoldoffCycles_Gen = 16,
    parameter int unsigned GrantTimeout_Gen  = 1024,
    parameter int unsigned MaxRetries_Gen    = 3
) (
    input  logic        SysClk_ClkIn,
    input  logic        SysRst_RstIn,
    input  logic        MsiIrqEnable_EnIn,
    input  logic        IrqReq_ValIn,
    input  logic [4:0]  IrqVectorNum_DatIn,
    output logic        IrqGrant_ValOut,
    output logic        MsiReq_ValOut,
    output logic [4:0]  MsiVectorNum_DatOut,
    input  logic        MsiGrant_ValIn,
    input  logic [2:0]  MsiVectorWidth_DatIn,
    output logic        Busy_ValOut,
    output logic [15:0] RetryCount_CntOut,
    output logic [15:0] DropCount_CntOut
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_GRANT,
        ST_HOLDOFF
    } state_t;

    localparam logic [15:0] TIMEOUT     = 16'(GrantTimeout_Gen);
    localparam logic [15:0] HOLDOFF     = 16'(HoldoffCycles_Gen);
    localparam logic [3:0]  MAX_RETRIES = 4'(MaxRetries_Gen);

    state_t      state_q, state_d;
    logic        msi_req_q, msi_req_d;
    logic        irq_grant_q, irq_grant_d;
    logic [4:0]  vec_q, vec_d;
    logic [15:0] timer_q, timer_d;
    logic [3:0]  retries_q, retries_d;
    logic [15:0] holdoff_q, holdoff_d;
    logic        pend_vld_q, pend_vld_d;
    logic [4:0]  pend_vec_q, pend_vec_d;
    logic [15:0] retry_cnt_q, retry_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    logic        accept;
    logic        finish;
    logic        src_vld;
    logic [4:0]  src_vec;
    logic        retry_inc;
    logic [1:0]  drop_inc;
    logic [15:0] timer_next;
    logic [16:0] drop_sum;

    function automatic logic [4:0] fold_vector(input logic [4:0] vec, input logic [2:0] width);
        logic [2:0] w_eff;
        logic [5:0] span;
        w_eff = (width > 3'd5) ? 3'd5 : width;
        span  = 6'd1 << w_eff;
        return ({1'b0, vec} < span) ? vec : 5'(span - 6'd1);
    endfunction

    always_comb begin
        state_d     = state_q;
        msi_req_d   = 1'b0;
        irq_grant_d = 1'b0;
        vec_d       = vec_q;
        timer_d     = timer_q;
        retries_d   = retries_q;
        holdoff_d   = holdoff_q;
        pend_vld_d  = pend_vld_q;
        pend_vec_d  = pend_vec_q;
        accept      = 1'b0;
        finish      = 1'b0;
        src_vld     = 1'b0;
        src_vec     = '0;
        retry_inc   = 1'b0;
        drop_inc    = '0;
        timer_next  = timer_q + 16'd1;

        if (!MsiIrqEnable_EnIn) begin
            state_d    = ST_IDLE;
            pend_vld_d = 1'b0;
            vec_d      = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: accept = 1'b1;
                ST_WAIT_GRANT: begin
                    if (MsiGrant_ValIn) begin
                        finish = 1'b1;
                    end else if (timer_next == TIMEOUT) begin
                        if (retries_q < MAX_RETRIES) begin
                            retries_d = retries_q + 4'd1;
                            retry_inc = 1'b1;
                            msi_req_d = 1'b1;
                            timer_d   = '0;
                        end else begin
                            drop_inc = drop_inc + 2'd1;
                            finish   = 1'b1;
                        end
                    end else begin
                        timer_d = timer_next;
                    end
                end
                // Holdoff expiry behaves as a pass through Idle, so a pending
                // request launches on the exit edge rather than one cycle later.
                ST_HOLDOFF: begin
                    if (holdoff_q == '0) begin
                        state_d = ST_IDLE;
                        accept  = 1'b1;
                    end else begin
                        holdoff_d = holdoff_q - 16'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (finish) begin
                irq_grant_d = 1'b1;
                if (HOLDOFF == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d   = ST_HOLDOFF;
                    holdoff_d = HOLDOFF;
                end
            end

            if (accept) begin
                if (pend_vld_q) begin
                    src_vld    = 1'b1;
                    src_vec    = pend_vec_q;
                    pend_vld_d = IrqReq_ValIn;
                    if (IrqReq_ValIn) pend_vec_d = IrqVectorNum_DatIn;
                end else if (IrqReq_ValIn) begin
                    src_vld = 1'b1;
                    src_vec = IrqVectorNum_DatIn;
                end
            end else if (IrqReq_ValIn) begin
                if (pend_vld_q) drop_inc = drop_inc + 2'd1;
                pend_vld_d = 1'b1;
                pend_vec_d = IrqVectorNum_DatIn;
            end

            if (src_vld) begin
                msi_req_d = 1'b1;
                vec_d     = fold_vector(src_vec, MsiVectorWidth_DatIn);
                timer_d   = '0;
                retries_d = '0;
                state_d   = ST_WAIT_GRANT;
            end
        end

        retry_cnt_d = (retry_inc && retry_cnt_q != '1) ? retry_cnt_q + 16'd1 : retry_cnt_q;
        drop_sum    = {1'b0, drop_cnt_q} + 17'(drop_inc);
        drop_cnt_d  = drop_sum[16] ? '1 : drop_sum[15:0];
    end

    always_ff @(posedge SysClk_ClkIn or posedge SysRst_RstIn) begin
        if (SysRst_RstIn) begin
            state_q     <= ST_IDLE;
            msi_req_q   <= 1'b0;
            irq_grant_q <= 1'b0;
            vec_q       <= '0;
            timer_q     <= '0;
            retries_q   <= '0;
            holdoff_q   <= '0;
            pend_vld_q  <= 1'b0;
            pend_vec_q  <= '0;
            retry_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            msi_req_q   <= msi_req_d;
            irq_grant_q <= irq_grant_d;
            vec_q       <= vec_d;
            timer_q     <= timer_d;
            retries_q   <= retries_d;
            holdoff_q   <= holdoff_d;
            pend_vld_q  <= pend_vld_d;
            pend_vec_q  <= pend_vec_d;
            retry_cnt_q <= retry_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign MsiReq_ValOut       = msi_req_q;
    assign IrqGrant_ValOut     = irq_grant_q;
    assign MsiVectorNum_DatOut = vec_q;
    assign Busy_ValOut         = (state_q != ST_IDLE);
    assign RetryCount_CntOut   = retry_cnt_q;
    assign DropCount_CntOut    = drop_cnt_q;

endmodule
